// File: rtl/nco_bpsk_sequencer.sv
// Purpose: frames bytes into a BPSK burst (preamble, MSB-first data, guard) driving NCO clk_en/pi.
// Latency: carrier enabled and first symbol strobe one cycle after the byte transfer edge.
// Backpressure: byte_ready only in IDLE or on the last cycle of a byte's final bit; `ifdef BPSK_DIFF_EN selects differential encoding.
module nco_bpsk_sequencer #(
    parameter int unsigned SYMBOL_CYCLES    = 16,
    parameter int unsigned PREAMBLE_SYMBOLS = 8,
    parameter int unsigned GUARD_SYMBOLS    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       nco_en,
    output logic       nco_pi,
    output logic       busy,
    output logic       sym_strobe
);

    localparam int unsigned CW = $clog2(SYMBOL_CYCLES);
    localparam int unsigned IW = 16;
    localparam logic [CW-1:0] CNT_LAST = CW'(SYMBOL_CYCLES - 1);
    localparam logic [IW-1:0] PRE_LAST = IW'(PREAMBLE_SYMBOLS - 1);
    localparam logic [IW-1:0] GRD_LAST = IW'(GUARD_SYMBOLS - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        GUARD    = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] sym_cnt;
    logic [IW-1:0] sym_idx;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          sym_last;
    logic          transfer;
    logic          next_bit;
    logic          next_pi;
`ifdef BPSK_DIFF_EN
    logic          phase;
`endif

    // Handshake and the phase of the data symbol that begins at the next edge.
    always_comb begin
        sym_last   = (sym_cnt == CNT_LAST);
        byte_ready = (state == IDLE) ||
                     ((state == DATA) && (bit_idx == 3'd0) && sym_last);
        transfer   = byte_valid && byte_ready;
        next_bit   = shift[7];
        if (state == DATA) begin
            if (bit_idx == 3'd0) begin
                next_bit = byte_data[7];
            end else begin
                next_bit = shift[bit_idx - 3'd1];
            end
        end
`ifdef BPSK_DIFF_EN
        // Leaving the preamble, the reference phase is the last preamble phase (1).
        next_pi = ((state == PREAMBLE) ? 1'b1 : phase) ^ next_bit;
`else
        next_pi = next_bit;
`endif
    end

    // Burst sequencer: symbol timing, framing and registered NCO controls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sym_cnt    <= '0;
            sym_idx    <= '0;
            bit_idx    <= 3'd7;
            shift      <= 8'd0;
            nco_en     <= 1'b0;
            nco_pi     <= 1'b0;
            busy       <= 1'b0;
            sym_strobe <= 1'b0;
`ifdef BPSK_DIFF_EN
            phase      <= 1'b0;
`endif
        end else begin
            sym_strobe <= 1'b0;
            case (state)
                IDLE: begin
                    if (transfer) begin
                        shift      <= byte_data;
                        state      <= PREAMBLE;
                        sym_cnt    <= '0;
                        sym_idx    <= '0;
                        nco_en     <= 1'b1;
                        nco_pi     <= 1'b0;
                        busy       <= 1'b1;
                        sym_strobe <= 1'b1;
                    end
                end
                PREAMBLE: begin
                    sym_cnt <= sym_last ? '0 : sym_cnt + 1'b1;
                    if (sym_last) begin
                        sym_strobe <= 1'b1;
                        if (sym_idx == PRE_LAST) begin
                            state   <= DATA;
                            sym_idx <= '0;
                            bit_idx <= 3'd7;
                            nco_pi  <= next_pi;
`ifdef BPSK_DIFF_EN
                            phase   <= next_pi;
`endif
                        end else begin
                            // Alternate phase: next symbol index parity.
                            sym_idx <= sym_idx + 1'b1;
                            nco_pi  <= ~sym_idx[0];
                        end
                    end
                end
                DATA: begin
                    sym_cnt <= sym_last ? '0 : sym_cnt + 1'b1;
                    if (sym_last) begin
                        sym_strobe <= 1'b1;
                        if (bit_idx == 3'd0) begin
                            if (transfer) begin
                                // Back-to-back byte: continue data with no new preamble.
                                shift   <= byte_data;
                                bit_idx <= 3'd7;
                                nco_pi  <= next_pi;
`ifdef BPSK_DIFF_EN
                                phase   <= next_pi;
`endif
                            end else begin
                                state   <= GUARD;
                                sym_idx <= '0;
                                nco_pi  <= 1'b0;
                            end
                        end else begin
                            bit_idx <= bit_idx - 3'd1;
                            nco_pi  <= next_pi;
`ifdef BPSK_DIFF_EN
                            phase   <= next_pi;
`endif
                        end
                    end
                end
                GUARD: begin
                    sym_cnt <= sym_last ? '0 : sym_cnt + 1'b1;
                    if (sym_last) begin
                        if (sym_idx == GRD_LAST) begin
                            state   <= IDLE;
                            sym_idx <= '0;
                            nco_en  <= 1'b0;
                            busy    <= 1'b0;
                        end else begin
                            sym_idx    <= sym_idx + 1'b1;
                            sym_strobe <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nco_bpsk_sequencer.sv
// Purpose: self-checking bench for nco_bpsk_sequencer (SYMBOL_CYCLES=4, PREAMBLE=8, GUARD=2).
// Latency: expected per-cycle outputs are queued at stimulus time and compared each negedge.
// Backpressure: held byte_valid exercises the back-to-back and guard-blocking handshake.
module tb_nco_bpsk_sequencer;

    localparam int SC = 4;
    localparam int PS = 8;
    localparam int GS = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] byte_data = 8'd0;
    logic       byte_valid = 1'b0;
    logic       byte_ready;
    logic       nco_en;
    logic       nco_pi;
    logic       busy;
    logic       sym_strobe;

    nco_bpsk_sequencer #(
        .SYMBOL_CYCLES   (SC),
        .PREAMBLE_SYMBOLS(PS),
        .GUARD_SYMBOLS   (GS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .byte_data (byte_data),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .nco_en    (nco_en),
        .nco_pi    (nco_pi),
        .busy      (busy),
        .sym_strobe(sym_strobe)
    );

    always #5 clk = ~clk;

    // {nco_en, nco_pi, sym_strobe, busy, byte_ready}
    typedef logic [4:0] exp_t;

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        int          nb;
        logic [15:0] pid;
        int          len;
        int          st;
    } vec_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cnt_st   = 0;
    int   cnt_en   = 0;

    // Scoreboard consumer and activity counters, sampled away from the active edge.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                a = {nco_en, nco_pi, sym_strobe, busy, byte_ready};
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL cycle_outputs t=%0t {en,pi,strobe,busy,ready} actual=%b required=%b",
                             $time, a, e);
                end
            end
            if (sym_strobe === 1'b1) cnt_st++;
            if (nco_en === 1'b1) cnt_en++;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic void push_rec(input logic en, input logic pi, input logic st,
                                     input logic bsy, input logic rdy);
        sb_q.push_back({en, pi, st, bsy, rdy});
    endfunction

    function automatic void push_idle(input int n);
        for (int i = 0; i < n; i++) push_rec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endfunction

    // Expected waveform: transfer cycle, preamble, data (pid MSB-first), guard.
    function automatic void push_burst(input logic [15:0] pid, input int nb);
        push_rec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int s = 0; s < PS; s++)
            for (int c = 0; c < SC; c++)
                push_rec(1'b1, s[0], c == 0, 1'b1, 1'b0);
        for (int k = 0; k < nb; k++)
            for (int b = 0; b < 8; b++)
                for (int c = 0; c < SC; c++)
                    push_rec(1'b1, pid[15 - (k * 8 + b)], c == 0, 1'b1,
                             (b == 7) && (c == SC - 1));
        for (int g = 0; g < GS; g++)
            for (int c = 0; c < SC; c++)
                push_rec(1'b1, 1'b0, c == 0, 1'b1, 1'b0);
    endfunction

    task automatic wait_drain();
        int b = 0;
        while (sb_q.size() != 0 && b < 3000) begin
            @(negedge clk);
            b++;
        end
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout remaining=%0d required=0", sb_q.size());
            sb_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Keep byte_valid high until a cycle with byte_ready, then drop it after that edge.
    task automatic hold_until_taken();
        int b = 0;
        @(negedge clk);
        while (byte_ready !== 1'b1 && b < 500) begin
            @(negedge clk);
            b++;
        end
        if (byte_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout actual=%b required=1", byte_ready);
        end
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    // Called just after a posedge in an idle cycle: that cycle is the transfer cycle T.
    task automatic run_vec(input vec_t v, input string name);
        int st0;
        int en0;
        st0 = cnt_st;
        en0 = cnt_en;
        push_burst(v.pid, v.nb);
        push_idle(2);
        byte_data  = v.b0;
        byte_valid = 1'b1;
        @(posedge clk);
        #1;
        if (v.nb == 2) begin
            byte_data = v.b1;
            hold_until_taken();
        end else begin
            byte_valid = 1'b0;
        end
        wait_drain();
        chk({name, "_strobes"}, cnt_st - st0, v.st);
        chk({name, "_en_cycles"}, cnt_en - en0, v.len);
    endtask

    initial begin
        vec_t        vecs[4];
        logic [15:0] pid_3c;
        logic [15:0] pid_a5;
        int          st0;
        int          en0;

`ifdef BPSK_DIFF_EN
        vecs[0] = '{b0: 8'hA5, b1: 8'h00, nb: 1, pid: 16'h3900, len: 72,  st: 18};
        vecs[1] = '{b0: 8'hFF, b1: 8'h00, nb: 2, pid: 16'h55FF, len: 104, st: 26};
        vecs[2] = '{b0: 8'h5A, b1: 8'hC3, nb: 2, pid: 16'h937D, len: 104, st: 26};
        vecs[3] = '{b0: 8'h00, b1: 8'h00, nb: 1, pid: 16'hFF00, len: 72,  st: 18};
        pid_3c  = 16'hD700;
        pid_a5  = 16'h3900;
`else
        vecs[0] = '{b0: 8'hA5, b1: 8'h00, nb: 1, pid: 16'hA500, len: 72,  st: 18};
        vecs[1] = '{b0: 8'hFF, b1: 8'h00, nb: 2, pid: 16'hFF00, len: 104, st: 26};
        vecs[2] = '{b0: 8'h5A, b1: 8'hC3, nb: 2, pid: 16'h5AC3, len: 104, st: 26};
        vecs[3] = '{b0: 8'h00, b1: 8'h00, nb: 1, pid: 16'h0000, len: 72,  st: 18};
        pid_3c  = 16'h3C00;
        pid_a5  = 16'hA500;
`endif

        // Reset asserted between edges takes effect at once.
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_nco_en", int'(nco_en), 0);
        chk("rst_nco_pi", int'(nco_pi), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(byte_ready), 1);
        chk("rst_strobe", int'(sym_strobe), 0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        st0 = cnt_st;
        en0 = cnt_en;
        push_idle(20);
        wait_drain();
        chk("idle_strobes", cnt_st - st0, 0);
        chk("idle_en_cycles", cnt_en - en0, 0);

        // Table of bursts: single bytes and back-to-back pairs.
        for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Byte offered during guard waits for the first IDLE cycle.
        st0 = cnt_st;
        push_burst(pid_a5, 1);
        byte_data  = 8'hA5;
        byte_valid = 1'b1;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        repeat (65) @(posedge clk);
        #1;
        byte_data  = 8'h3C;
        byte_valid = 1'b1;
        push_burst(pid_3c, 1);
        push_idle(2);
        hold_until_taken();
        wait_drain();
        chk("guard_hold_strobes", cnt_st - st0, 36);

        // Reset in the middle of the data phase drops outputs without an edge.
        byte_data  = 8'hA5;
        byte_valid = 1'b1;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        repeat (39) @(posedge clk);
        #1;
        chk("mid_data_busy", int'(busy), 1);
        chk("mid_data_en", int'(nco_en), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_en", int'(nco_en), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_pi", int'(nco_pi), 0);
        chk("mid_rst_ready", int'(byte_ready), 1);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_vec(vecs[3], "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nco_bpsk_sequencer.md
Name: nco_bpsk_sequencer

Overview:
- Controller for the NCO's `clk_en` and `pi` (phase-invert) inputs; turns the NCO carrier into a BPSK-modulated burst.
- Accepts bytes over a valid/ready handshake and frames each burst as preamble, then data bits MSB-first, then guard.
- Sits between a byte source and the NCO, in the `pll_clock` domain.
- Drives carrier enable and phase each symbol period.

Parameters:
- SYMBOL_CYCLES, 16: clocks per symbol; legal range 2..65535.
- PREAMBLE_SYMBOLS, 8: alternating-phase symbols before the first data bit; even, at least 2.
- GUARD_SYMBOLS, 2: unmodulated (pi=0) symbols after the last byte; at least 1.

Ports:
- clk, input, 1: system clock (`pll_clock` domain).
- rst_n, input, 1: asynchronous active-low reset.
- byte_data, input, 8: byte to transmit.
- byte_valid, input, 1: byte_data is valid.
- byte_ready, output, 1: sequencer accepts byte_data this cycle.
- nco_en, output, 1: drives NCO `clk_en`.
- nco_pi, output, 1: drives NCO `pi`; 1 = 180° phase.
- busy, output, 1: state is not IDLE.
- sym_strobe, output, 1: one-cycle pulse on the first cycle of every symbol.

Behaviour:
- Reset (rst_n low, acts immediately):
  - state=IDLE, sym_cnt=0, sym_idx=0, bit_idx=7, shift register=0.
  - nco_en=0, nco_pi=0, busy=0, sym_strobe=0, byte_ready=1.
  - No transfer completes while rst_n is low.
- A transfer occurs on a clock edge where byte_valid and byte_ready are both 1.
- byte_ready is combinational. It is 1 when:
  - state is IDLE, or
  - state is DATA, bit_idx=0 and sym_cnt=SYMBOL_CYCLES-1 (last cycle of the last bit).
- It is 0 at all other times, including PREAMBLE and GUARD.
- sym_cnt counts 0..SYMBOL_CYCLES-1 and wraps to 0. A symbol ends at sym_cnt=SYMBOL_CYCLES-1.
- All outputs except byte_ready are registered.
- States:
  - IDLE: nco_en=0, nco_pi=0.
    - On transfer at edge T: latch byte, go to PREAMBLE.
    - nco_en=1 from cycle T+1; sym_strobe=1 at T+1.
  - PREAMBLE: nco_en=1.
    - nco_pi = sym_idx[0], i.e. 0,1,0,1,…; the last preamble symbol is 1.
    - After PREAMBLE_SYMBOLS symbols, go to DATA with bit_idx=7.
  - DATA: nco_en=1; nco_pi = encode(shift[bit_idx]).
    - At the end of each symbol, bit_idx decrements.
    - At the end of the bit_idx=0 symbol with a transfer: load the new byte, bit_idx=7, stay in DATA. No preamble is inserted.
    - At the end of the bit_idx=0 symbol without a transfer: go to GUARD.
  - GUARD: nco_en=1, nco_pi=0 for GUARD_SYMBOLS symbols, then IDLE.
    - byte_valid is ignored in GUARD.
    - A held byte is accepted in the first IDLE cycle and starts a new preamble.
- sym_strobe pulses at every symbol start in PREAMBLE, DATA and GUARD. It never pulses in IDLE.
- Burst length for N back-to-back bytes: (PREAMBLE_SYMBOLS + 8N + GUARD_SYMBOLS) × SYMBOL_CYCLES cycles of nco_en=1.
- Reset mid-burst: outputs drop to reset values asynchronously. The partial byte is discarded and not retransmitted.

Optional Feature:
- Macro: BPSK_DIFF_EN.
- Defined: differential encoding.
  - An internal phase register is loaded with 1 (the last preamble phase) on entering DATA.
  - At each data symbol start it toggles if the bit is 1 and holds if the bit is 0. nco_pi = phase register.
  - The phase register persists across back-to-back bytes.
  - In GUARD and IDLE, nco_pi=0 regardless of the register.
- Undefined: nco_pi = data bit directly; no phase register exists.

Test Plan (SYMBOL_CYCLES=4, PREAMBLE_SYMBOLS=8, GUARD_SYMBOLS=2):
1. Assert rst_n=0 mid-clock with no edge, then release. Required: nco_en=0, nco_pi=0, busy=0, byte_ready=1 immediately; 20 idle cycles give no sym_strobe.
2. Transfer 0xA5 at edge T. Required:
   - T+1..T+32: nco_en=1, nco_pi=0,1,0,1,0,1,0,1 per 4-cycle symbol.
   - T+33..T+64: nco_pi=1,0,1,0,0,1,0,1.
   - T+65..T+72: nco_pi=0.
   - T+73: nco_en=0, busy=0, byte_ready=1.
   - 18 sym_strobe pulses total.
3. Hold byte_valid with 0xFF, then 0x00. Required:
   - byte_ready pulses alone at T+64 and 0x00 is taken there.
   - T+65..T+96 nco_pi=0, with no preamble in between.
   - Guard ends at T+104.
4. Pull rst_n low at T+40 (mid-DATA). Required: nco_en=0 and busy=0 in the same cycle with no edge needed; after release, the next transfer starts with a full preamble.
5. Assert byte_valid=1 with 0x3C from T+66 (during GUARD). Required: byte_ready=0 until T+73, transfer at T+73, preamble starts T+74.
6. With BPSK_DIFF_EN defined, send 0xA5. Required: data nco_pi=0,0,1,1,1,0,0,1; preamble and guard are unchanged from test 2.
